// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared constants and types for the 16x16 serial router output
//            arbitration logic.
// Contents : N_PORTS, ADDR_W, arb_state_t, port_idx_t
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int N_PORTS = 16;
    localparam int ADDR_W  = $clog2(N_PORTS);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [ADDR_W-1:0] port_idx_t;

endpackage
`default_nettype wire

// File: rtl/router_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : router_rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set bit of
//            the candidate mask scanning ptr+1, ptr+2, ... modulo N_PORTS,
//            so the bit at ptr itself is considered last.
// Ports    : cand   in  N_PORTS  candidate mask
//            ptr    in  ADDR_W   last winner (lowest priority)
//            found  out 1        at least one candidate present
//            winner out ADDR_W   selected index (0 when found=0)
// Revision : 1.0 - initial release
// ============================================================================
module router_rr_pick
    import router_pkg::*;
(
    input  logic [N_PORTS-1:0] cand,
    input  port_idx_t          ptr,
    output logic               found,
    output port_idx_t          winner
);

    port_idx_t idx;

    // Scan from the lowest priority slot upwards so the last hit is the
    // highest priority one; avoids a break in the loop.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            idx = ptr + port_idx_t'(k);
            if (cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter
// Purpose  : Per-output-port round-robin scheduler. Each output grants one
//            requesting input, holds the grant for the whole frame and
//            releases it when the input drops req or after MAX_HOLD cycles.
// Ports    : clock       in  1                 rising-edge clock
//            reset_n     in  1                 synchronous active-low reset
//            req         in  N_PORTS           per-input request
//            req_dest    in  N_PORTS*ADDR_W    per-input destination
//            gnt         out N_PORTS           input owns its output
//            out_busy    out N_PORTS           output is granted
//            out_src     out N_PORTS*ADDR_W    owning input per output
//            timeout_err out N_PORTS           one-cycle forced-release pulse
// Revision : 1.0 - initial release
// ============================================================================
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int MAX_HOLD = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*ADDR_W-1:0] req_dest,
    output logic [N_PORTS-1:0]        gnt,
    output logic [N_PORTS-1:0]        out_busy,
    output logic [N_PORTS*ADDR_W-1:0] out_src,
    output logic [N_PORTS-1:0]        timeout_err
);

    localparam int                 HOLD_W    = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = {HOLD_W{1'b1}};

    arb_state_t          state_q [N_PORTS];
    arb_state_t          state_d [N_PORTS];
    port_idx_t           ptr_q   [N_PORTS];
    port_idx_t           ptr_d   [N_PORTS];
    port_idx_t           src_q   [N_PORTS];
    port_idx_t           src_d   [N_PORTS];
    logic [HOLD_W-1:0]   hold_q  [N_PORTS];
    logic [HOLD_W-1:0]   hold_d  [N_PORTS];
    logic [N_PORTS-1:0]  timeout_q, timeout_d;
    // block_rearm: input was force-released and must drop req before
    // it may compete again.
    logic [N_PORTS-1:0]  block_rearm_q, block_rearm_d;

    logic [N_PORTS-1:0]  cand [N_PORTS];
    logic [N_PORTS-1:0]  found;
    port_idx_t           winner [N_PORTS];

    // Grant vector is derived from the owner registers, so it always agrees
    // with out_busy/out_src.
    always_comb begin
        gnt = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == ARB_BUSY) begin
                gnt[src_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            cand[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                cand[o][i] = req[i]
                           && (req_dest[i*ADDR_W +: ADDR_W] == port_idx_t'(o))
                           && !gnt[i]
                           && !block_rearm_q[i];
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_out
        router_rr_pick u_pick (
            .cand   (cand[o]),
            .ptr    (ptr_q[o]),
            .found  (found[o]),
            .winner (winner[o])
        );
        assign out_busy[o]                  = (state_q[o] == ARB_BUSY);
        assign out_src[o*ADDR_W +: ADDR_W]  = src_q[o];
    end

    assign timeout_err = timeout_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        src_d         = src_q;
        hold_d        = hold_q;
        timeout_d     = '0;
        block_rearm_d = block_rearm_q & req;
        for (int o = 0; o < N_PORTS; o++) begin
            case (state_q[o])
                ARB_IDLE: begin
                    if (found[o]) begin
                        state_d[o] = ARB_BUSY;
                        src_d[o]   = winner[o];
                        ptr_d[o]   = winner[o];
                        hold_d[o]  = '0;
                    end
                end
                ARB_BUSY: begin
                    if (!req[src_q[o]]) begin
                        state_d[o] = ARB_IDLE;
                    end else if (hold_q[o] == HOLD_LAST) begin
                        state_d[o]                = ARB_IDLE;
                        timeout_d[o]              = 1'b1;
                        block_rearm_d[src_q[o]]   = 1'b1;
                    end else if (hold_q[o] != HOLD_SAT) begin
                        hold_d[o] = hold_q[o] + HOLD_W'(1);
                    end
                end
                default: state_d[o] = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= ARB_IDLE;
                ptr_q[o]   <= port_idx_t'(N_PORTS - 1);
                src_q[o]   <= '0;
                hold_q[o]  <= '0;
            end
            timeout_q     <= '0;
            block_rearm_q <= '0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
                src_q[o]   <= src_d[o];
                hold_q[o]  <= hold_d[o];
            end
            timeout_q     <= timeout_d;
            block_rearm_q <= block_rearm_d;
        end
    end

endmodule
`default_nettype wire
